climate_sample_driver: RTL and testbench
========================================

CLIMATE_SAMPLE_DRIVER -- requirements
Module: climate_sample_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of sample-memory entries.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for predictor done.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  sample-memory write strobe.
REQ-006 SHALL have port wr_addr  input  3  sample-memory write index.
REQ-007 SHALL have port wr_temp  input  8  signed temperature to store.
REQ-008 SHALL have port wr_press  input  11  unsigned pressure to store.
REQ-009 SHALL have port num_samples  input  4  samples to play; sampled on accepted start.
REQ-010 SHALL have port start  input  1  begin playback.
REQ-011 SHALL have port temperature  output  8  signed sample driven to predictor.
REQ-012 SHALL have port pressure  output  11  sample driven to predictor.
REQ-013 SHALL have port climate_condition  input  3  predictor result.
REQ-014 SHALL have port done  input  1  predictor result-valid pulse.
REQ-015 SHALL have port busy  output  1  playback in progress.
REQ-016 SHALL have port finished  output  1  one-cycle end-of-playback pulse.
REQ-017 SHALL have port last_condition  output  3  most recently recorded condition.
REQ-018 SHALL have ports cnt_snow, cnt_sunny, cnt_storm, cnt_error  output  4 each  per-run condition counts.
REQ-019 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states IDLE, DRIVE, WAIT, FIN.
REQ-021 IDLE: start=1 SHALL latch min(num_samples, DEPTH), clear idx, all counters and timeout_err, and go to DRIVE; with num_samples=0 it SHALL go straight to FIN.
REQ-022 DRIVE: if mem[idx] equals current temperature/pressure outputs, the FSM SHALL record last_condition again without waiting (predictor sees no change); otherwise it SHALL register mem[idx] onto temperature/pressure and go to WAIT.
REQ-023 WAIT: on done=1 the FSM SHALL record climate_condition.
REQ-024 Recording SHALL set last_condition and increment the matching counter; codes UNDEFINED(0) and 4..7 SHALL increment cnt_error.
REQ-025 After a recording, the FSM SHALL increment idx; when idx reaches the latched count it SHALL go to FIN, else to DRIVE.
REQ-026 FIN SHALL assert finished for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in DRIVE and WAIT and 0 in IDLE and FIN.
REQ-028 start and wr_en SHALL be ignored unless in IDLE.
REQ-029 done outside WAIT SHALL be ignored.
REQ-030 temperature/pressure SHALL hold their values between samples and after FIN.

Reset
REQ-031 rst SHALL force IDLE, temperature=0, pressure=0, last_condition=0, all counters=0, busy=0, finished=0, timeout_err=0; mid-run reset SHALL abort with no finished pulse.
REQ-032 Sample-memory contents SHALL NOT be cleared by rst.

Configuration
REQ-033 With CLIMATE_DRV_TIMEOUT_EN defined, a WAIT counter SHALL run; after TIMEOUT cycles without done, the FSM SHALL set timeout_err, record ERROR(4), and advance per REQ-025.
REQ-034 Without CLIMATE_DRV_TIMEOUT_EN, WAIT SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-035 Package climate_pkg SHALL hold the climate_t encoding (UNDEFINED=0, SNOW=1, SUNNY=2, STORM=3, ERROR=4) and the driver state enum.
REQ-036 The sample store SHALL be sub-module climate_sample_mem: DEPTH x 19 bits, synchronous write, combinational read.

Verification
REQ-037 Load (0,975),(15,1010),(30,900); start, num=3; connect climate_prediction -> counts snow=1, sunny=1, storm=1; one finished pulse.
REQ-038 Two identical samples (5,960),(5,960) -> second recorded via skip without done; cnt_snow=2; no timeout_err.
REQ-039 num_samples=0 -> finished one cycle after start; busy stays 0; temperature and pressure unchanged.
REQ-040 With CLIMATE_DRV_TIMEOUT_EN and done tied low, num=1 -> timeout_err=1 after 16 WAIT cycles; cnt_error=1; finished pulses.
REQ-041 rst asserted in WAIT -> next cycle IDLE, all outputs at reset values, no finished pulse; a subsequent start runs normally.
REQ-042 num_samples=12 -> exactly 8 samples played; counts sum to 8.

Source files
------------

// File: rtl/climate_pkg.sv
`default_nettype none
//==============================================================================
// Module   : climate_pkg
// Brief    : Shared encodings for the climate sample driver.
// Revision : 1.0 - initial release
//==============================================================================
package climate_pkg;

    localparam int ADDR_W   = 3;
    localparam int SAMPLE_W = 19;

    typedef enum logic [2:0] {
        UNDEFINED = 3'd0,
        SNOW      = 3'd1,
        SUNNY     = 3'd2,
        STORM     = 3'd3,
        ERROR     = 3'd4
    } climate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/climate_sample_mem.sv
`default_nettype none
//==============================================================================
// Module   : climate_sample_mem
// Brief    : DEPTH x 19-bit sample store, synchronous write, combinational read.
// Revision : 1.0 - initial release
//==============================================================================
module climate_sample_mem
    import climate_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data
);

    // No reset: stored samples survive rst so a run can be repeated.
    logic [SAMPLE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/climate_sample_driver.sv
`default_nettype none
//==============================================================================
// Module   : climate_sample_driver
// Brief    : Plays stored samples into a climate predictor and tallies results.
//            Define CLIMATE_DRV_TIMEOUT_EN to enable the WAIT-state timeout.
// Revision : 1.0 - initial release
//==============================================================================
module climate_sample_driver
    import climate_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_temp,
    input  logic [10:0] wr_press,
    input  logic [3:0]  num_samples,
    input  logic        start,
    output logic [7:0]  temperature,
    output logic [10:0] pressure,
    input  logic [2:0]  climate_condition,
    input  logic        done,
    output logic        busy,
    output logic        finished,
    output logic [2:0]  last_condition,
    output logic [3:0]  cnt_snow,
    output logic [3:0]  cnt_sunny,
    output logic [3:0]  cnt_storm,
    output logic [3:0]  cnt_error,
    output logic        timeout_err
);

    localparam logic [3:0] c_max_n = 4'(DEPTH);

    drv_state_t          r_state;
    logic [3:0]          r_idx;
    logic [3:0]          r_count;
    logic [7:0]          r_temp;
    logic [10:0]         r_press;
    logic [2:0]          r_last;
    logic [3:0]          r_cnt_snow;
    logic [3:0]          r_cnt_sunny;
    logic [3:0]          r_cnt_storm;
    logic [3:0]          r_cnt_error;
    logic                r_busy;
    logic                r_finished;

    logic [SAMPLE_W-1:0] w_rd_data;
    logic                w_hit;
    logic                w_rec_en;
    logic [2:0]          w_rec_code;
    logic                w_timeout;
    logic [3:0]          w_n_latch;
    logic [3:0]          w_idx_nxt;

    climate_sample_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (wr_en && (r_state == IDLE)),
        .i_wr_addr (wr_addr),
        .i_wr_data ({wr_temp, wr_press}),
        .i_rd_addr (r_idx[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign w_hit     = (w_rd_data == {r_temp, r_press});
    assign w_n_latch = (num_samples > c_max_n) ? c_max_n : num_samples;
    assign w_idx_nxt = r_idx + 4'd1;

`ifdef CLIMATE_DRV_TIMEOUT_EN
    localparam int                c_tw        = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0]   c_wait_last = c_tw'(TIMEOUT - 1);

    logic [c_tw-1:0] r_wait_cnt;
    logic            r_timeout_err;

    assign w_timeout   = (r_state == WAIT) && !done && (r_wait_cnt == c_wait_last);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
            if (r_state == IDLE && start) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT;

    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // A skipped sample re-records the previous result; a timeout records ERROR.
    always_comb begin
        w_rec_en   = 1'b0;
        w_rec_code = r_last;
        case (r_state)
            DRIVE: begin
                if (w_hit) begin
                    w_rec_en = 1'b1;
                end
            end
            WAIT: begin
                if (done) begin
                    w_rec_en   = 1'b1;
                    w_rec_code = climate_condition;
                end else if (w_timeout) begin
                    w_rec_en   = 1'b1;
                    w_rec_code = ERROR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_temp      <= '0;
            r_press     <= '0;
            r_last      <= '0;
            r_cnt_snow  <= '0;
            r_cnt_sunny <= '0;
            r_cnt_storm <= '0;
            r_cnt_error <= '0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count     <= w_n_latch;
                        r_idx       <= '0;
                        r_cnt_snow  <= '0;
                        r_cnt_sunny <= '0;
                        r_cnt_storm <= '0;
                        r_cnt_error <= '0;
                        if (w_n_latch == 4'd0) begin
                            r_state    <= FIN;
                            r_finished <= 1'b1;
                        end else begin
                            r_state <= DRIVE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (!w_hit) begin
                        r_temp  <= w_rd_data[SAMPLE_W-1:11];
                        r_press <= w_rd_data[10:0];
                        r_state <= WAIT;
                    end
                end
                WAIT: ;
                FIN: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_rec_en) begin
                r_last <= w_rec_code;
                case (w_rec_code)
                    SNOW:    r_cnt_snow  <= r_cnt_snow + 4'd1;
                    SUNNY:   r_cnt_sunny <= r_cnt_sunny + 4'd1;
                    STORM:   r_cnt_storm <= r_cnt_storm + 4'd1;
                    default: r_cnt_error <= r_cnt_error + 4'd1;
                endcase
                r_idx <= w_idx_nxt;
                if (w_idx_nxt == r_count) begin
                    r_state    <= FIN;
                    r_busy     <= 1'b0;
                    r_finished <= 1'b1;
                end else begin
                    r_state <= DRIVE;
                end
            end
        end
    end

    assign temperature    = r_temp;
    assign pressure       = r_press;
    assign last_condition = r_last;
    assign cnt_snow       = r_cnt_snow;
    assign cnt_sunny      = r_cnt_sunny;
    assign cnt_storm      = r_cnt_storm;
    assign cnt_error      = r_cnt_error;
    assign busy           = r_busy;
    assign finished       = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_climate_sample_driver.sv
`default_nettype none
//==============================================================================
// Module   : tb_climate_sample_driver
// Brief    : Directed self-checking bench with a behavioural predictor model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_climate_sample_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_temp;
    logic [10:0] wr_press;
    logic [3:0]  num_samples;
    logic        start;
    logic [7:0]  temperature;
    logic [10:0] pressure;
    logic [2:0]  climate_condition = 3'd0;
    logic        done = 1'b0;
    logic        busy;
    logic        finished;
    logic [2:0]  last_condition;
    logic [3:0]  cnt_snow, cnt_sunny, cnt_storm, cnt_error;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic        pred_en = 1'b1;
    logic [7:0]  p_t = 8'd0;
    logic [10:0] p_p = 11'd0;
    int          p_pend = 0;
    int          done_total = 0;
    int          fin_total = 0;

    climate_sample_driver #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_temp           (wr_temp),
        .wr_press          (wr_press),
        .num_samples       (num_samples),
        .start             (start),
        .temperature       (temperature),
        .pressure          (pressure),
        .climate_condition (climate_condition),
        .done              (done),
        .busy              (busy),
        .finished          (finished),
        .last_condition    (last_condition),
        .cnt_snow          (cnt_snow),
        .cnt_sunny         (cnt_sunny),
        .cnt_storm         (cnt_storm),
        .cnt_error         (cnt_error),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    // Predictor: storm below 950, else snow at or below 5 degrees, else sunny.
    function automatic logic [2:0] classify(input logic [7:0] t, input logic [10:0] p);
        if (p < 11'd950) return 3'd3;
        else if ($signed(t) <= 8'sd5) return 3'd1;
        else return 3'd2;
    endfunction

    always @(negedge clk) begin
        done = 1'b0;
        if (finished === 1'b1) fin_total++;
        if (temperature !== p_t || pressure !== p_p) begin
            p_t    = temperature;
            p_p    = pressure;
            p_pend = 3;
        end else if (p_pend > 0) begin
            p_pend--;
            if (p_pend == 0 && pred_en) begin
                done              = 1'b1;
                climate_condition = classify(p_t, p_p);
                done_total++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int a, input int t, input int p);
        wr_en    = 1'b1;
        wr_addr  = 3'(a);
        wr_temp  = 8'(t);
        wr_press = 11'(p);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        num_samples = 4'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fin(input int max_cyc, output int cyc);
        cyc = 0;
        while (finished !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        if (finished !== 1'b1) begin
            n_checks++;
            $display("FAIL wait_finished: no finished pulse within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (temperature !== 8'd0) $display("FAIL rst_temp: got %0d expected 0", temperature); else n_pass++;
        n_checks++; if (pressure !== 11'd0) $display("FAIL rst_press: got %0d expected 0", pressure); else n_pass++;
        n_checks++; if (last_condition !== 3'd0) $display("FAIL rst_last: got %0d expected 0", last_condition); else n_pass++;
        n_checks++; if ({cnt_snow, cnt_sunny, cnt_storm, cnt_error} !== 16'h0) $display("FAIL rst_counts: got %h expected 0000", {cnt_snow, cnt_sunny, cnt_storm, cnt_error}); else n_pass++;
        n_checks++; if ({busy, finished, timeout_err} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {busy, finished, timeout_err}); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_three_samples();
        int cyc, f0;
        write_mem(0, 0, 975);
        write_mem(1, 15, 1010);
        write_mem(2, 30, 900);
        f0 = fin_total;
        pulse_start(3);
        n_checks++; if (busy !== 1'b1) $display("FAIL three_busy: got %b expected 1", busy); else n_pass++;
        write_mem(2, -20, 1000);  // must be ignored while busy
        wait_fin(200, cyc);
        n_checks++; if (cnt_snow !== 4'd1) $display("FAIL three_snow: got %0d expected 1", cnt_snow); else n_pass++;
        n_checks++; if (cnt_sunny !== 4'd1) $display("FAIL three_sunny: got %0d expected 1", cnt_sunny); else n_pass++;
        n_checks++; if (cnt_storm !== 4'd1) $display("FAIL three_storm: got %0d expected 1", cnt_storm); else n_pass++;
        n_checks++; if (cnt_error !== 4'd0) $display("FAIL three_error: got %0d expected 0", cnt_error); else n_pass++;
        n_checks++; if (last_condition !== 3'd3) $display("FAIL three_last: got %0d expected 3", last_condition); else n_pass++;
        n_checks++; if ({temperature, pressure} !== {8'd30, 11'd900}) $display("FAIL three_sample: got %0d/%0d expected 30/900", temperature, pressure); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL three_busy_fin: got %b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (finished !== 1'b0) $display("FAIL three_fin_len: got %b expected 0", finished); else n_pass++;
        n_checks++; if (fin_total - f0 !== 1) $display("FAIL three_fin_count: got %0d expected 1", fin_total - f0); else n_pass++;
    endtask

    task automatic test_skip();
        int cyc, d0;
        write_mem(0, 5, 960);
        write_mem(1, 5, 960);
        d0 = done_total;
        pulse_start(2);
        wait_fin(200, cyc);
        n_checks++; if (cnt_snow !== 4'd2) $display("FAIL skip_snow: got %0d expected 2", cnt_snow); else n_pass++;
        n_checks++; if (cnt_error !== 4'd0) $display("FAIL skip_error: got %0d expected 0", cnt_error); else n_pass++;
        n_checks++; if (done_total - d0 !== 1) $display("FAIL skip_done_count: got %0d expected 1", done_total - d0); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL skip_timeout: got %b expected 0", timeout_err); else n_pass++;
        tick();
    endtask

    task automatic test_zero();
        int f0;
        f0 = fin_total;
        pulse_start(0);
        n_checks++; if (finished !== 1'b1) $display("FAIL zero_fin: got %b expected 1", finished); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if ({finished, busy} !== 2'b00) $display("FAIL zero_after: got %b expected 00", {finished, busy}); else n_pass++;
        n_checks++; if ({temperature, pressure} !== {8'd5, 11'd960}) $display("FAIL zero_hold: got %0d/%0d expected 5/960", temperature, pressure); else n_pass++;
        n_checks++; if (fin_total - f0 !== 1) $display("FAIL zero_fin_count: got %0d expected 1", fin_total - f0); else n_pass++;
    endtask

    task automatic test_depth_clamp();
        int cyc, d0;
        int tv[8] = '{-10, 20, 25, 3, 40, -5, 10, 0};
        int pv[8] = '{1000, 1000, 940, 990, 1020, 900, 980, 1005};
        for (int i = 0; i < 8; i++) write_mem(i, tv[i], pv[i]);
        d0 = done_total;
        pulse_start(12);
        repeat (3) tick();
        pulse_start(1);  // must be ignored while busy
        wait_fin(400, cyc);
        n_checks++; if ({cnt_snow, cnt_sunny, cnt_storm, cnt_error} !== {4'd3, 4'd3, 4'd2, 4'd0}) $display("FAIL clamp_counts: got %h expected 3320", {cnt_snow, cnt_sunny, cnt_storm, cnt_error}); else n_pass++;
        n_checks++; if (done_total - d0 !== 8) $display("FAIL clamp_played: got %0d expected 8", done_total - d0); else n_pass++;
        n_checks++; if ({temperature, pressure} !== {8'd0, 11'd1005}) $display("FAIL clamp_last_sample: got %0d/%0d expected 0/1005", temperature, pressure); else n_pass++;
        n_checks++; if (last_condition !== 3'd1) $display("FAIL clamp_last: got %0d expected 1", last_condition); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cyc, f0;
        f0 = fin_total;
        pulse_start(8);
        tick();  // now in WAIT for sample 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({busy, finished} !== 2'b00) $display("FAIL midrst_flags: got %b expected 00", {busy, finished}); else n_pass++;
        n_checks++; if ({temperature, pressure, last_condition} !== 22'h0) $display("FAIL midrst_outputs: got %0d/%0d/%0d expected 0/0/0", temperature, pressure, last_condition); else n_pass++;
        n_checks++; if ({cnt_snow, cnt_sunny, cnt_storm, cnt_error} !== 16'h0) $display("FAIL midrst_counts: got %h expected 0000", {cnt_snow, cnt_sunny, cnt_storm, cnt_error}); else n_pass++;
        repeat (6) tick();
        n_checks++; if (fin_total - f0 !== 0) $display("FAIL midrst_no_fin: got %0d expected 0", fin_total - f0); else n_pass++;
        pulse_start(2);
        wait_fin(200, cyc);
        n_checks++; if ({cnt_snow, cnt_sunny, cnt_storm, cnt_error} !== {4'd1, 4'd1, 4'd0, 4'd0}) $display("FAIL midrst_rerun: got %h expected 1100", {cnt_snow, cnt_sunny, cnt_storm, cnt_error}); else n_pass++;
        n_checks++; if ({temperature, pressure} !== {8'd20, 11'd1000}) $display("FAIL midrst_rerun_sample: got %0d/%0d expected 20/1000", temperature, pressure); else n_pass++;
        tick();
    endtask

`ifdef CLIMATE_DRV_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        pred_en = 1'b0;
        write_mem(0, 50, 1000);
        pulse_start(1);
        wait_fin(100, cyc);
        n_checks++; if (cyc !== 17) $display("FAIL to_latency: got %0d expected 17", cyc); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %b expected 1", timeout_err); else n_pass++;
        n_checks++; if (cnt_error !== 4'd1) $display("FAIL to_error: got %0d expected 1", cnt_error); else n_pass++;
        n_checks++; if (last_condition !== 3'd4) $display("FAIL to_last: got %0d expected 4", last_condition); else n_pass++;
        tick();
        pred_en = 1'b1;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = 3'd0;
        wr_temp     = 8'd0;
        wr_press    = 11'd0;
        num_samples = 4'd0;
        start       = 1'b0;
        test_reset();
        test_three_samples();
        test_skip();
        test_zero();
        test_depth_clamp();
        test_reset_mid_run();
`ifdef CLIMATE_DRV_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
